keccak_round_ctrl: RTL and testbench
====================================

# keccak_round_ctrl

Sequencer for the iterative Keccak-f[1600] permutation in the low-throughput core. It accepts a permutation request from the padder/absorb logic and issues a one-cycle load strobe to the state register. It then steps the 24-bit one-hot round selector that drives `rconst` and the round datapath, one round per enabled cycle, and presents the finished state through a valid/ready handshake. It owns no datapath state, only control.

## Interface
- `ROUNDS`, default 24: rounds per permutation; legal range 1..24. The one-hot vector stays 24 bits wide regardless of this value.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; 0 forces reset immediately.
- `start`  in  1  permutation request; accepted when `start & ready`.
- `ready`  out  1  controller idle and able to accept `start`.
- `stall`  in  1  freezes round stepping, honoured in ROUND only.
- `abort`  in  1  synchronous abandon; returns to IDLE from any state.
- `load`  out  1  one-cycle strobe: datapath captures the input block into state.
- `round_en`  out  1  datapath applies one round this cycle.
- `i`  out  24  one-hot round selector to `rconst`; bit k means round k.
- `round_idx`  out  5  binary index of the set bit of `i`; 0 when `i` is 0.
- `out_valid`  out  1  state register holds the permutation result.
- `out_ready`  in  1  consumer takes the result when `out_valid & out_ready`.

## Operation
- States: IDLE, LOAD, ROUND, DONE. Encoding is free.
- IDLE:
  - `ready`=1; all other outputs 0; `i`=0.
  - `start & ~abort` moves to LOAD.
- LOAD:
  - `load`=1 for exactly one cycle. `stall` is ignored here.
  - Next state is ROUND with `i`<=24'h000001.
- ROUND:
  - `round_en` = ~`stall`.
  - When `round_en`=1 and `i[ROUNDS-1]`=0: `i` <= `i`<<1.
  - When `round_en`=1 and `i[ROUNDS-1]`=1: `i`<=0 and the state moves to DONE.
  - When `stall`=1: `i` and the state are held, and `round_en`=0.
- DONE:
  - `out_valid`=1 and `i`=0.
  - `out_ready` returns the block to IDLE.
  - `out_valid` stays high until accepted; it never drops without `out_ready` or `abort`.
- `abort`=1 in any state: next state is IDLE and `i`<=0. `abort` has priority over `start`, `stall` and `out_ready`.
- Ignored inputs:
  - `start` outside IDLE.
  - `out_ready` outside DONE.
  - `stall` outside ROUND.
- `round_idx` is a combinational encode of `i`. Its value is only meaningful while `round_en`=1.
- Invariant: `i` is always either 0 or exactly one-hot, and it is nonzero only in ROUND.

## Timing
- Reset values while `reset`=0 and after release: state IDLE, `i`=0, `round_idx`=0, `load`=0, `round_en`=0, `out_valid`=0, `ready`=1.
- `ready`, `load`, `round_en` and `out_valid` are decoded from registered state and `stall` only. They have no combinational path from `start`, `abort` or `out_ready`.
- Start accepted at edge T, no stalls:
  - `load`=1 in cycle T+1.
  - `round_en`=1 in cycles T+2 .. T+1+ROUNDS, with `i` = bit 0 .. bit ROUNDS-1 in turn.
  - `out_valid`=1 from cycle T+2+ROUNDS.
  - Latency from `start` to `out_valid` is ROUNDS+2 cycles. Each stall cycle in ROUND adds one cycle.
- Back-to-back operation: `out_ready` accepted at edge U gives `ready`=1 in cycle U+1. The earliest next `load` is cycle U+2, so there is one IDLE cycle minimum between permutations.
- Reset asserted mid-permutation: outputs take their reset values immediately (asynchronously). There is no partial result and no `out_valid` pulse.
- `abort` in the same cycle that `i[ROUNDS-1]` would complete: go to IDLE, not DONE.

## Test plan
- Reset then a single start with ROUNDS=24, no stall, `out_ready` tied to 1:
  - `load` pulses in cycle 1 after acceptance.
  - `i` walks 24'h000001 .. 24'h800000 over 24 consecutive `round_en` cycles.
  - `round_idx` goes 0..23.
  - `out_valid` is high for one cycle at acceptance+26.
- Stall pattern (assert `stall` in the 3rd, 10th and 11th ROUND cycles):
  - `round_en` is low on exactly those cycles and `i` holds its value on each.
  - `out_valid` arrives at acceptance+29.
  - `stall` asserted during LOAD has no effect.
- Result backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - `out_valid` stays 1 and `i` stays 0.
  - `start` pulses during DONE are ignored.
  - `ready` rises the cycle after `out_ready`=1.
- Abort:
  - Assert `abort` while `i`=24'h000400; the next cycle shows IDLE, `i`=0, `ready`=1, and no `out_valid`.
  - Assert `start` and `abort` together in IDLE; the controller stays IDLE.
- Async reset: drive `reset` low mid-ROUND between clock edges.
  - `i`, `round_en` and `out_valid` go 0 immediately and `ready` goes 1.
  - After release, a fresh start completes normally.
- ROUNDS=1 instance:
  - `load`, then a single `round_en` with `i`=24'h000001 and `round_idx`=0.
  - `out_valid` at acceptance+3.

Source files
------------

// File: rtl/keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keccak_round_ctrl
// Purpose  : Control sequencer for the iterative Keccak-f[1600] core. It
//            handles load, one-hot round stepping and the result handshake.
// Revision : 1.0
// ============================================================================
module keccak_round_ctrl #(
    parameter int ROUNDS = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    input  logic        stall,
    input  logic        abort,
    output logic        load,
    output logic        round_en,
    output logic [23:0] i,
    output logic [4:0]  round_idx,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_load  = 2'd1;
    localparam logic [1:0] c_round = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    // Out-of-range ROUNDS values are clamped so the last-round tap stays inside the 24-bit vector.
    localparam int c_last = (ROUNDS < 1) ? 0 : ((ROUNDS > 24) ? 23 : ROUNDS - 1);

    logic [1:0]  r_state;
    logic [23:0] r_i;
    logic [4:0]  w_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_idle;
            r_i     <= '0;
        end else if (abort) begin
            r_state <= c_idle;
            r_i     <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_state <= c_load;
                    end
                end
                c_load: begin
                    r_state <= c_round;
                    r_i     <= 24'h000001;
                end
                c_round: begin
                    if (!stall) begin
                        if (r_i[c_last]) begin
                            r_i     <= '0;
                            r_state <= c_done;
                        end else begin
                            r_i <= r_i << 1;
                        end
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_i     <= '0;
                end
            endcase
        end
    end

    // With at most one bit set, OR-ing the indices of set bits yields the binary index.
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < 24; k++) begin
            if (r_i[k]) begin
                w_idx = w_idx | 5'(k);
            end
        end
    end

    assign ready     = (r_state == c_idle);
    assign load      = (r_state == c_load);
    assign round_en  = (r_state == c_round) & ~stall;
    assign out_valid = (r_state == c_done);
    assign i         = r_i;
    assign round_idx = w_idx;

endmodule
`default_nettype wire

// File: tb/tb_keccak_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keccak_round_ctrl
// Purpose  : Directed self-checking bench for keccak_round_ctrl (ROUNDS=24 and ROUNDS=1).
// Revision : 1.0
// ============================================================================
module tb_keccak_round_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        abort;
    logic        out_ready;

    logic        ready, load, round_en, out_valid;
    logic [23:0] i;
    logic [4:0]  round_idx;

    logic        ready_1, load_1, round_en_1, out_valid_1;
    logic [23:0] i_1;
    logic [4:0]  round_idx_1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keccak_round_ctrl #(.ROUNDS(24)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .stall(stall),
        .abort(abort), .load(load), .round_en(round_en), .i(i), .round_idx(round_idx),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    keccak_round_ctrl #(.ROUNDS(1)) dut_1 (
        .clk(clk), .reset(reset), .start(start), .ready(ready_1), .stall(stall),
        .abort(abort), .load(load_1), .round_en(round_en_1), .i(i_1), .round_idx(round_idx_1),
        .out_valid(out_valid_1), .out_ready(out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0; out_ready = 1'b0;
        #3;
        total++;
        if ({ready, load, round_en, out_valid} !== 4'b1000 || i !== 24'h0 || round_idx !== 5'd0) begin
            bad++;
            $display("FAIL reset_hold: rdy/ld/ren/ov=%b i=%h idx=%0d, want 1000 i=0 idx=0",
                     {ready, load, round_en, out_valid}, i, round_idx);
        end
        step();
        step();
        reset = 1'b1;
        step();
        total++;
        if ({ready, load, round_en, out_valid} !== 4'b1000 || i !== 24'h0) begin
            bad++;
            $display("FAIL reset_release: rdy/ld/ren/ov=%b i=%h, want 1000 i=0",
                     {ready, load, round_en, out_valid}, i);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (load !== 1'b1 || ready !== 1'b0 || round_en !== 1'b0) begin
            bad++;
            $display("FAIL single_load: load=%b ready=%b ren=%b, want 1 0 0", load, ready, round_en);
        end
        for (int k = 0; k < 24; k++) begin
            step();
            total++;
            if (round_en !== 1'b1 || i !== (24'h1 << k) || round_idx !== 5'(k) || load !== 1'b0) begin
                bad++;
                $display("FAIL single_round%0d: ren=%b i=%h idx=%0d load=%b, want 1 %h %0d 0",
                         k, round_en, i, round_idx, load, 24'h1 << k, k);
            end
        end
        step();
        total++;
        if (out_valid !== 1'b1 || i !== 24'h0 || round_en !== 1'b0) begin
            bad++;
            $display("FAIL single_valid: ov=%b i=%h ren=%b, want 1 0 0", out_valid, i, round_en);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL single_after: ov=%b ready=%b, want 0 1", out_valid, ready);
        end
    endtask

    task automatic test_stall();
        int exp_bit;
        logic stl;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        stall = 1'b1;
        #1;
        total++;
        if (load !== 1'b1 || round_en !== 1'b0) begin
            bad++;
            $display("FAIL stall_load: load=%b ren=%b, want 1 0", load, round_en);
        end
        exp_bit = 0;
        for (int c = 1; c <= 27; c++) begin
            step();
            stl = (c == 3 || c == 10 || c == 11);
            stall = stl;
            #1;
            total++;
            if (round_en !== ~stl || i !== (24'h1 << exp_bit)) begin
                bad++;
                $display("FAIL stall_cycle%0d: ren=%b i=%h, want %b %h", c, round_en, i, ~stl, 24'h1 << exp_bit);
            end
            if (!stl) exp_bit++;
        end
        step();
        stall = 1'b0;
        total++;
        if (out_valid !== 1'b1 || i !== 24'h0) begin
            bad++;
            $display("FAIL stall_valid: ov=%b i=%h, want 1 0", out_valid, i);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 25; k++) step();
        for (int c = 0; c < 5; c++) begin
            total++;
            if (out_valid !== 1'b1 || i !== 24'h0 || ready !== 1'b0 || load !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: ov=%b i=%h ready=%b load=%b, want 1 0 0 0",
                         c, out_valid, i, ready, load);
            end
            start = (c % 2 == 0);
            step();
            start = 1'b0;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (ready !== 1'b1 || out_valid !== 1'b0 || load !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: ready=%b ov=%b load=%b, want 1 0 0", ready, out_valid, load);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b1;
        total++;
        if (load !== 1'b1) begin
            bad++;
            $display("FAIL b2b_load: load=%b, want 1", load);
        end
        for (int k = 0; k < 25; k++) step();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_valid: ov=%b, want 1", out_valid);
        end
        step();
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 11; k++) step();
        total++;
        if (i !== 24'h000400 || round_idx !== 5'd10) begin
            bad++;
            $display("FAIL abort_pre: i=%h idx=%0d, want 000400 10", i, round_idx);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (ready !== 1'b1 || i !== 24'h0 || out_valid !== 1'b0 || round_en !== 1'b0) begin
            bad++;
            $display("FAIL abort_mid: ready=%b i=%h ov=%b ren=%b, want 1 0 0 0", ready, i, out_valid, round_en);
        end
        step();
        total++;
        if (ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL abort_settle: ready=%b ov=%b, want 1 0", ready, out_valid);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 24; k++) step();
        total++;
        if (i !== 24'h800000) begin
            bad++;
            $display("FAIL abort_lastpre: i=%h, want 800000", i);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++;
        if (ready !== 1'b1 || out_valid !== 1'b0 || i !== 24'h0) begin
            bad++;
            $display("FAIL abort_last: ready=%b ov=%b i=%h, want 1 0 0", ready, out_valid, i);
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (ready !== 1'b1 || load !== 1'b0) begin
            bad++;
            $display("FAIL abort_start_idle: ready=%b load=%b, want 1 0", ready, load);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 5; k++) step();
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (i !== 24'h0 || round_en !== 1'b0 || out_valid !== 1'b0 || ready !== 1'b1 || round_idx !== 5'd0) begin
            bad++;
            $display("FAIL areset_mid: i=%h ren=%b ov=%b ready=%b idx=%0d, want 0 0 0 1 0",
                     i, round_en, out_valid, ready, round_idx);
        end
        #1;
        reset = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (load !== 1'b1) begin
            bad++;
            $display("FAIL areset_reload: load=%b, want 1", load);
        end
        for (int k = 0; k < 24; k++) begin
            step();
            total++;
            if (round_en !== 1'b1 || i !== (24'h1 << k)) begin
                bad++;
                $display("FAIL areset_round%0d: ren=%b i=%h, want 1 %h", k, round_en, i, 24'h1 << k);
            end
        end
        step();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL areset_valid: ov=%b, want 1", out_valid);
        end
        step();
    endtask

    task automatic test_rounds1();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        total++;
        if (load_1 !== 1'b1 || round_en_1 !== 1'b0) begin
            bad++;
            $display("FAIL r1_load: load=%b ren=%b, want 1 0", load_1, round_en_1);
        end
        step();
        total++;
        if (round_en_1 !== 1'b1 || i_1 !== 24'h000001 || round_idx_1 !== 5'd0) begin
            bad++;
            $display("FAIL r1_round: ren=%b i=%h idx=%0d, want 1 000001 0", round_en_1, i_1, round_idx_1);
        end
        step();
        total++;
        if (out_valid_1 !== 1'b1 || i_1 !== 24'h0 || round_en_1 !== 1'b0) begin
            bad++;
            $display("FAIL r1_valid: ov=%b i=%h ren=%b, want 1 0 0", out_valid_1, i_1, round_en_1);
        end
        step();
        total++;
        if (ready_1 !== 1'b1 || out_valid_1 !== 1'b0) begin
            bad++;
            $display("FAIL r1_idle: ready=%b ov=%b, want 1 0", ready_1, out_valid_1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_rounds1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
